// File: rtl/store_aligner_pkg.sv
// Shared definitions for the store alignment path.
// Size encodings match the load-extension path, so both sides of the
// memory stage agree on byte/half/word codes. Also holds the FSM state
// type and the lane-steering helpers used by store_aligner.
package store_aligner_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // A store is rejected when its size is illegal or its address is not
    // naturally aligned to that size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Replicate the narrow value across all lanes so the byte enables alone
    // select which bytes memory actually updates.
    function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] size, input logic [DATA_W-1:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/store_aligner_queue.sv
// store_queue: DEPTH-entry synchronous FIFO of packed store entries.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   push_i, data_i  write an entry (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   head_o          oldest entry
//   next_o          entry behind the head (valid when count_o >= 2)
//   count_o         number of stored entries
//   full_o, empty_o occupancy flags
module store_queue #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 68,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [W-1:0]     next_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    assign rd_nxt = rd_ptr_q + PTR_W'(1);
    assign head_o = mem_q[rd_ptr_q];
    assign next_o = mem_q[rd_nxt];

    // NOTE: storage array has no reset; contents are never observed until
    // written, and leaving it out keeps it mappable to plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_nxt;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/store_aligner.sv
// store_aligner: narrows a register value to byte/half/word, steers it onto
// the right byte lanes of a word-aligned memory write, and queues it until
// data memory acknowledges. Misaligned stores are consumed and flagged but
// never written.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   st_valid_i/st_ready_o              store request handshake
//   st_addr_i, st_data_i, st_size_i    byte address, register data, size code
//   mem_req_o/mem_ack_i                memory write request / acceptance
//   mem_addr_o, mem_wdata_o, mem_be_o  word address, lane data, byte enables
//   misaligned_o                       one-cycle pulse after a rejected store
//   busy_o                             queue non-empty or request outstanding
module store_aligner
    import store_aligner_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [1:0]        st_size_i,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic              misaligned_o,
    output logic              busy_o
);

    localparam int unsigned ENT_W = ADDR_W + DATA_W + BE_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENT_W-1:0]  in_ent, head_ent, next_ent, load_ent;
    logic [CNT_W-1:0]  count;
    logic              q_full, q_empty;
    logic              hs, bad, push, pop, load;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              mis_q;

    // Full blocks intake even if an ack frees a slot this cycle.
    assign st_ready_o = !q_full && !rst_i;
    assign hs         = st_valid_i && st_ready_o;
    assign bad        = is_misaligned(st_size_i, st_addr_i[1:0]);
    assign push       = hs && !bad;
    assign pop        = (state_q == ST_REQ) && mem_ack_i;

    assign in_ent = {st_addr_i[ADDR_W-1:2], 2'b00,
                     lane_wdata(st_size_i, st_data_i),
                     lane_be(st_size_i, st_addr_i[1:0])};

    // The head stays queued while it is being requested and is popped on ack,
    // so queue occupancy alone decides st_ready.
    store_queue #(.DEPTH(DEPTH), .W(ENT_W)) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (in_ent),
        .pop_i   (pop),
        .head_o  (head_ent),
        .next_o  (next_ent),
        .count_o (count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        load     = 1'b0;
        load_ent = head_ent;
        case (state_q)
            ST_IDLE: begin
                // An empty queue bypasses the incoming store straight to the
                // output registers, giving one-cycle request latency.
                if (!q_empty || push) begin
                    load     = 1'b1;
                    load_ent = q_empty ? in_ent : head_ent;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    // After the pop, the next head is either the second
                    // queued entry or the store being pushed this cycle.
                    if (count > CNT_W'(1)) begin
                        load     = 1'b1;
                        load_ent = next_ent;
                    end else if (push) begin
                        load     = 1'b1;
                        load_ent = in_ent;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            {addr_d, wdata_d, be_d} = load_ent;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mis_q   <= hs && bad;
        end
    end

    assign mem_req_o    = (state_q == ST_REQ);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;
    assign misaligned_o = mis_q;
    assign busy_o       = !q_empty || (state_q == ST_REQ);

endmodule

// File: tb/tb_store_aligner.sv
module tb_store_aligner;
    import store_aligner_pkg::*;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misaligned;
    logic        busy;
    logic [70:0] obs;

    int checks = 0;
    int errors = 0;

    store_aligner #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .st_valid_i   (st_valid),
        .st_ready_o   (st_ready),
        .st_addr_i    (st_addr),
        .st_data_i    (st_data),
        .st_size_i    (st_size),
        .mem_req_o    (mem_req),
        .mem_ack_i    (mem_ack),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .misaligned_o (misaligned),
        .busy_o       (busy)
    );

    // {mem_req, mem_addr, mem_wdata, mem_be, busy, misaligned}
    assign obs = {mem_req, mem_addr, mem_wdata, mem_be, busy, misaligned};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", st_ready); end
        checks++;
        if (obs !== 71'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        rst = 1'b0;
        #1;
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", st_ready); end
    endtask

    task automatic issue_single(input string name, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s, input logic [31:0] ea,
                                input logic [31:0] ew, input logic [3:0] eb);
        @(negedge clk);
        drive(a, d, s);
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, st_ready); end
        @(negedge clk);
        st_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, ea, ew, eb, 1'b1, 1'b0})
            begin errors++; $display("FAIL %s_req: got %h expected %h", name, obs, {1'b1, ea, ew, eb, 1'b1, 1'b0}); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (obs !== {1'b0, ea, ew, eb, 1'b0, 1'b0})
            begin errors++; $display("FAIL %s_done: got %h expected %h", name, obs, {1'b0, ea, ew, eb, 1'b0, 1'b0}); end
    endtask

    task automatic test_word();
        issue_single("sw_1000", 32'h1000, 32'hDEADBEEF, SZ_WORD, 32'h1000, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_lanes();
        issue_single("sb_2003", 32'h2003, 32'h12345678, SZ_BYTE, 32'h2000, 32'h78787878, 4'b1000);
        issue_single("sh_2002", 32'h2002, 32'h0000ABCD, SZ_HALF, 32'h2000, 32'hABCDABCD, 4'b1100);
        issue_single("sb_2001", 32'h2001, 32'h000000A5, SZ_BYTE, 32'h2000, 32'hA5A5A5A5, 4'b0010);
        issue_single("sh_2000", 32'h2000, 32'hFFFF1234, SZ_HALF, 32'h2000, 32'h12341234, 4'b0011);
        issue_single("sw_2004", 32'h2004, 32'hCAFEF00D, SZ_WORD, 32'h2004, 32'hCAFEF00D, 4'hF);
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h3001; sizes[0] = SZ_HALF;
        addrs[1] = 32'h3002; sizes[1] = SZ_WORD;
        addrs[2] = 32'h3000; sizes[2] = SZ_ILL;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(addrs[i], 32'h55AA55AA, sizes[i]);
            checks++;
            if (st_ready !== 1'b1) begin errors++; $display("FAIL mis%0d_ready: got %b expected 1", i, st_ready); end
            @(negedge clk);
            st_valid = 1'b0;
            checks++;
            if ({mem_req, busy, misaligned} !== 3'b001)
                begin errors++; $display("FAIL mis%0d_pulse: req/busy/mis got %b expected 001", i, {mem_req, busy, misaligned}); end
            @(negedge clk);
            checks++;
            if ({mem_req, busy, misaligned} !== 3'b000)
                begin errors++; $display("FAIL mis%0d_after: req/busy/mis got %b expected 000", i, {mem_req, busy, misaligned}); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(32'h4000, 32'h11111111, SZ_WORD);
        @(negedge clk);
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", st_ready); end
        drive(32'h4004, 32'h22222222, SZ_WORD);
        @(negedge clk);
        st_valid = 1'b0;
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b expected 0", st_ready); end
        checks++;
        if (obs !== {1'b1, 32'h4000, 32'h11111111, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL b2b_first: got %h", obs); end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 32'h4000, 32'h11111111, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL b2b_hold: got %h", obs); end
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 32'h4004, 32'h22222222, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL b2b_second: got %h", obs); end
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b expected 1", st_ready); end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (obs !== {1'b0, 32'h4004, 32'h22222222, 4'hF, 1'b0, 1'b0})
            begin errors++; $display("FAIL b2b_idle: got %h", obs); end
    endtask

    task automatic test_full_ack();
        @(negedge clk);
        drive(32'h5000, 32'hC0C0C0C0, SZ_WORD);
        @(negedge clk);
        drive(32'h5004, 32'hD0D0D0D0, SZ_WORD);
        @(negedge clk);
        drive(32'h5008, 32'hE0E0E0E0, SZ_WORD);
        mem_ack = 1'b1;
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ack_ready: got %b expected 0", st_ready); end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (st_ready !== 1'b1) begin errors++; $display("FAIL full_not_taken: ready got %b expected 1", st_ready); end
        checks++;
        if (obs !== {1'b1, 32'h5004, 32'hD0D0D0D0, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL full_second: got %h", obs); end
        @(negedge clk);
        st_valid = 1'b0;
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL full_taken_later: ready got %b expected 0", st_ready); end
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 32'h5008, 32'hE0E0E0E0, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL full_third: got %h", obs); end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (obs !== {1'b0, 32'h5008, 32'hE0E0E0E0, 4'hF, 1'b0, 1'b0})
            begin errors++; $display("FAIL full_idle: got %h", obs); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(32'h6000, 32'h0A0B0C0D, SZ_WORD);
        @(negedge clk);
        drive(32'h6006, 32'h00001234, SZ_HALF);
        @(negedge clk);
        st_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 32'h6000, 32'h0A0B0C0D, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL rmid_req: got %h", obs); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 71'h0) begin errors++; $display("FAIL rmid_async: got %h expected 0", obs); end
        checks++;
        if (st_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0", st_ready); end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 71'h0) begin errors++; $display("FAIL rmid_stale%0d: got %h expected 0", i, obs); end
        end
        mem_ack = 1'b0;
        issue_single("post_rst", 32'h7001, 32'h000000A5, SZ_BYTE, 32'h7000, 32'hA5A5A5A5, 4'b0010);
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_misaligned();
        test_back_to_back();
        test_full_ack();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
